sram_row_sequencer: RTL
=======================

// Module: sram_row_sequencer
// PURPOSE
//  Sequences one row access at a time into the 6T SRAM cell array (ROWS x DATA_W cells).
//  Converts a clocked valid/ready request into three phases: wordline, bitline drive and
//  read_pulse/write_pulse timing. Captures read data from the sensed bitlines and returns it.
//  Sits between the core load/store path and the cell array.
// PARAMETERS
//  ADDR_W     4  row address width; ROWS = 2**ADDR_W one-hot wordlines
//  DATA_W     8  cells per row (bitline pairs)
//  SETUP_CYC  1  cycles WL/bitlines are stable before the pulse rises (>=1)
//  PULSE_CYC  2  cycles read_pulse/write_pulse stay high (>=1)
//  HOLD_CYC   1  cycles WL/bitlines are held after the pulse falls (>=1)
// PORTS
//  clk          in   1           system clock, all logic on posedge
//  rst_n        in   1           synchronous reset, active-low
//  req_valid    in   1           request present
//  req_ready    out  1           sequencer can accept a request
//  req_we       in   1           1=write, 0=read
//  req_addr     in   ADDR_W      row index
//  req_wdata    in   DATA_W      write data (BL1 value; BL2 = ~req_wdata)
//  rsp_valid    out  1           one-cycle pulse: read data valid / write retired
//  rsp_rdata    out  DATA_W      captured read data (held until next read)
//  rsp_err      out  1           bitline complement error, qualified by rsp_valid
//  wl           out  2**ADDR_W   one-hot wordlines
//  bl1_drv      out  DATA_W      true bitline drive value
//  bl2_drv      out  DATA_W      complement bitline drive value
//  bl_oe        out  1           bitline drivers enabled (write phases only)
//  read_pulse   out  1           array read strobe
//  write_pulse  out  1           array write strobe; cells latch on its falling edge
//  bl1_sense    in   DATA_W      sensed BL1out bus
//  bl2_sense    in   DATA_W      sensed BL2out bus
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE. All outputs 0, except req_ready=1.
//    rsp_rdata is cleared to 0. Reset in any phase aborts the access on the next edge:
//    wl, the pulses and bl_oe drop in the same cycle. No rsp_valid is produced.
//  - FSM: IDLE -> SETUP -> PULSE -> HOLD -> IDLE. A down-counter loads
//    SETUP_CYC/PULSE_CYC/HOLD_CYC on entry to each phase and advances at 1.
//  - Accept: req_valid && req_ready at posedge. This latches we, addr and wdata, then
//    goes to SETUP. req_ready=1 only in IDLE. Requests are never queued.
//  - SETUP: wl[addr]=1. On a write, bl_oe=1, bl1_drv=wdata and bl2_drv=~wdata.
//    On a read, bl_oe=0 and the drive buses are 0.
//  - PULSE: wl and bitlines are held. read_pulse or write_pulse=1, never both.
//  - Read capture: on the last PULSE cycle, bl1_sense is registered into rsp_rdata,
//    before read_pulse falls. Bits that are X/Z capture as 0.
//  - HOLD: pulses are 0. wl and write drive are held; this is the write latch edge.
//  - rsp_valid pulses for 1 cycle on the HOLD->IDLE transition. That transition is also
//    the first cycle where req_ready=1.
//  - Access latency, accept edge to rsp_valid: SETUP_CYC+PULSE_CYC+HOLD_CYC cycles
//    (4 with defaults). Back-to-back accesses: one IDLE cycle between accesses minimum.
//  - wl is always one-hot or all-zero. Address decode uses only the low ADDR_W bits.
//  - All outputs are registered. There is no combinational path from req_* to array pins.
// CONFIGURATION
//  SRAM_ROW_SEQ_BLCHECK_EN defined:
//    - On the read capture cycle, rsp_err is registered as |(bl1_sense ~^ bl2_sense).
//      This flags any bit where BL1 == BL2.
//    - It is presented with rsp_valid and cleared on the next accept.
//  SRAM_ROW_SEQ_BLCHECK_EN undefined:
//    - rsp_err is tied to 0 and bl2_sense is unused.
//  Write accesses always report rsp_err=0.
// TESTING
//  1. Reset: rst_n=0 for 2 cycles.
//     -> req_ready=1; wl=0, pulses=0, bl_oe=0, rsp_valid=0, rsp_rdata=0.
//  2. Write addr=3, wdata=8'hA5, then read addr=3.
//     -> write: wl=16'h0008, bl1_drv=A5, bl2_drv=5A for 4 cycles; write_pulse high 2 cycles.
//     -> read: rsp_rdata=8'hA5 with rsp_valid 4 cycles after accept.
//  3. Hold req_valid=1 continuously with 3 alternating writes/reads.
//     -> req_ready is low during each access; exactly 1 IDLE cycle between accesses.
//     -> read_pulse and write_pulse are never both high.
//  4. Read with bl1_sense=8'hFF, bl2_sense=8'h00.
//     -> rsp_err=0.
//     Read with bl2_sense=8'hFF (macro on).
//     -> rsp_err=1 with rsp_valid. Macro off -> rsp_err=0.
//  5. Assert rst_n=0 during PULSE of a write.
//     -> next edge: write_pulse=0, wl=0, bl_oe=0, no rsp_valid; req_ready=1 after release.
//  6. Run with SETUP_CYC=2, PULSE_CYC=3, HOLD_CYC=2.
//     -> latency is 7 cycles; pulse width is 3; wl is high for all 7 cycles.

Source files
------------

// File: rtl/sram_row_sequencer.sv
// sram_row_sequencer: runs one SRAM row access at a time through three phases.
// The phases are SETUP (wordline and bitlines settle), PULSE (read/write strobe)
// and HOLD (write latch). Read data is captured from the sensed BL1 bus.
// Optional feature macro: SRAM_ROW_SEQ_BLCHECK_EN. When it is defined, the block
// flags sensed bitline pairs that are not complementary on reads (rsp_err).
//
// state | meaning
// IDLE  | waiting for a request, req_ready=1
// SETUP | wordline/bitlines driven, strobe low
// PULSE | read_pulse or write_pulse high; read data captured on last cycle
// HOLD  | strobe low, wordline/write drive held while cells latch
module sram_row_sequencer #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 rsp_valid,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err,
  output logic [2**ADDR_W-1:0] wl,
  output logic [DATA_W-1:0]    bl1_drv,
  output logic [DATA_W-1:0]    bl2_drv,
  output logic                 bl_oe,
  output logic                 read_pulse,
  output logic                 write_pulse,
  input  logic [DATA_W-1:0]    bl1_sense,
  input  logic [DATA_W-1:0]    bl2_sense
);

  localparam int ROWS = 2**ADDR_W;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              accept, capture, done;

  // Accept only from IDLE (where req_ready is high); requests are never queued.
  assign accept = (state_q == IDLE) && req_valid;

  // Next-state logic: each phase loads its length and counts down to 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = SETUP;
          cnt_d   = CNT_W'(SETUP_CYC);
        end
      end
      SETUP: begin
        if (cnt_q == CNT_ONE) begin
          state_d = PULSE;
          cnt_d   = CNT_W'(PULSE_CYC);
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      PULSE: begin
        if (cnt_q == CNT_ONE) begin
          state_d = HOLD;
          cnt_d   = CNT_W'(HOLD_CYC);
          capture = !we_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      HOLD: begin
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
          done    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Array-pin values for the coming cycle. On the accept edge, the request
  // fields are used directly so the wordline rises in the first SETUP cycle.
  logic              we_sel, active;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic [ROWS-1:0]   wl_d;

  // Next values for the registered array outputs.
  always_comb begin
    we_sel    = accept ? req_we    : we_q;
    addr_sel  = accept ? req_addr  : addr_q;
    wdata_sel = accept ? req_wdata : wdata_q;
    active    = (state_d != IDLE);
    wl_d      = '0;
    if (active) wl_d[addr_sel] = 1'b1;
  end

  // State, request latch and registered outputs; reset aborts any access at once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      wl          <= '0;
      bl1_drv     <= '0;
      bl2_drv     <= '0;
      bl_oe       <= 1'b0;
      read_pulse  <= 1'b0;
      write_pulse <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      req_ready   <= (state_d == IDLE);
      rsp_valid   <= done;
      wl          <= wl_d;
      bl_oe       <= active && we_sel;
      bl1_drv     <= (active && we_sel) ? wdata_sel  : '0;
      bl2_drv     <= (active && we_sel) ? ~wdata_sel : '0;
      read_pulse  <= (state_d == PULSE) && !we_sel;
      write_pulse <= (state_d == PULSE) && we_sel;
      // Per-bit test so that unknown sensed bits land as 0.
      if (capture) begin
        for (int i = 0; i < DATA_W; i++) begin
          if (bl1_sense[i]) rsp_rdata[i] <= 1'b1;
          else              rsp_rdata[i] <= 1'b0;
        end
      end
    end
  end

`ifdef SRAM_ROW_SEQ_BLCHECK_EN
  // Flag any bitline pair that sensed equal on a read; cleared by the next accept.
  always_ff @(posedge clk) begin
    if (!rst_n)       rsp_err <= 1'b0;
    else if (accept)  rsp_err <= 1'b0;
    else if (capture) rsp_err <= |(bl1_sense ~^ bl2_sense);
  end
`else
  logic unused_bl2;
  assign unused_bl2 = ^bl2_sense;
  assign rsp_err    = 1'b0;
`endif

endmodule
